// File: rtl/lpc_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lpc_frame_scheduler_if
// Brief    : Frame buffer / engine / coefficient-stream bundle of the LPC
//            frame scheduler.
// Revision : 1.0
// ============================================================================
interface lpc_frame_scheduler_if #(
    parameter int ORDER = 10,
    parameter int CNT_W = 16
);
    logic             frame_rdy;
    logic             frame_ack;
    logic             ac_start;
    logic             ac_done;
    logic             lev_start;
    logic             lev_done;
    logic [ORDER-1:0] coef_rsel;
    logic             coef_valid;
    logic             coef_ready;
    logic             coef_last;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        input  frame_rdy, ac_done, lev_done, coef_ready,
        output frame_ack, ac_start, lev_start, coef_rsel, coef_valid,
               coef_last, busy, err, frame_cnt, drop_cnt
    );

    modport slave (
        output frame_rdy, ac_done, lev_done, coef_ready,
        input  frame_ack, ac_start, lev_start, coef_rsel, coef_valid,
               coef_last, busy, err, frame_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lpc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lpc_frame_scheduler
// Brief    : Runs autocorrelation, Levinson and coefficient streaming for one
//            LPC frame, with a per-engine watchdog. All outputs registered.
// Revision : 1.0
// ============================================================================
module lpc_frame_scheduler #(
    parameter int ORDER   = 10,
    parameter int TIMEOUT = 4095,
    parameter int CNT_W   = 16
) (
    input wire clk,
    input wire reset,
    lpc_frame_scheduler_if.master bus
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] c_WD_TERM = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AC_RUN  = 3'd1,
        S_LEV_RUN = 3'd2,
        S_OUT     = 3'd3,
        S_ACK     = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             frame_ack_q, frame_ack_d;
    logic             ac_start_q, ac_start_d;
    logic             lev_start_q, lev_start_d;
    logic [ORDER-1:0] coef_rsel_q, coef_rsel_d;
    logic             coef_valid_q, coef_valid_d;
    logic             coef_last_q, coef_last_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d     = state_q;
        wd_d        = '0;
        frame_ack_d = 1'b0;
        ac_start_d  = 1'b0;
        lev_start_d = 1'b0;
        coef_rsel_d = '0;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.frame_rdy) begin
                    state_d    = S_AC_RUN;
                    ac_start_d = 1'b1;
                end
            end
            // The start-pulse cycle masks done; done beats the terminal count.
            S_AC_RUN: begin
                wd_d = wd_q + 1'b1;
                if (!ac_start_q && bus.ac_done) begin
                    state_d     = S_LEV_RUN;
                    lev_start_d = 1'b1;
                    wd_d        = '0;
                end else if (wd_q == c_WD_TERM) begin
                    state_d     = S_DROP;
                    frame_ack_d = 1'b1;
                    drop_cnt_d  = drop_cnt_q + 1'b1;
                    err_d       = 1'b1;
                end
            end
            S_LEV_RUN: begin
                wd_d = wd_q + 1'b1;
                if (!lev_start_q && bus.lev_done) begin
                    state_d     = S_OUT;
                    coef_rsel_d = ORDER'(1);
                    wd_d        = '0;
                end else if (wd_q == c_WD_TERM) begin
                    state_d     = S_DROP;
                    frame_ack_d = 1'b1;
                    drop_cnt_d  = drop_cnt_q + 1'b1;
                    err_d       = 1'b1;
                end
            end
            S_OUT: begin
                coef_rsel_d = coef_rsel_q;
                if (coef_valid_q && bus.coef_ready) begin
                    if (coef_rsel_q[ORDER-1]) begin
                        state_d     = S_ACK;
                        coef_rsel_d = '0;
                        frame_ack_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        coef_rsel_d = coef_rsel_q << 1;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_DROP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        coef_valid_d = (state_d == S_OUT);
        coef_last_d  = coef_valid_d & coef_rsel_d[ORDER-1];
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            frame_ack_q  <= 1'b0;
            ac_start_q   <= 1'b0;
            lev_start_q  <= 1'b0;
            coef_rsel_q  <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            frame_ack_q  <= frame_ack_d;
            ac_start_q   <= ac_start_d;
            lev_start_q  <= lev_start_d;
            coef_rsel_q  <= coef_rsel_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.frame_ack  = frame_ack_q;
    assign bus.ac_start   = ac_start_q;
    assign bus.lev_start  = lev_start_q;
    assign bus.coef_rsel  = coef_rsel_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.coef_last  = coef_last_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpc_frame_scheduler
// Brief    : Self-checking bench; expected timing derived per frame from the
//            engine delays and ready pattern chosen for that frame.
// Revision : 1.0
// ============================================================================
module tb_lpc_frame_scheduler;

    localparam int ORDER   = 10;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lpc_frame_scheduler_if #(.ORDER(ORDER), .CNT_W(CNT_W)) bus ();

    lpc_frame_scheduler #(
        .ORDER   (ORDER),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [CNT_W-1:0] exp_fc;
    logic [CNT_W-1:0] exp_dc;
    bit               exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // beat < 0 means no coefficient is on the bus in this cycle.
    task automatic check_cycle(input string tag, input bit e_ac, input bit e_lev,
                               input bit e_ack, input bit e_busy, input int beat);
        logic [ORDER-1:0] e_rsel;
        e_rsel = (beat >= 0) ? (ORDER'(1) << beat) : '0;
        check({tag, ".ac_start"},   32'(bus.ac_start),   32'(e_ac));
        check({tag, ".lev_start"},  32'(bus.lev_start),  32'(e_lev));
        check({tag, ".frame_ack"},  32'(bus.frame_ack),  32'(e_ack));
        check({tag, ".busy"},       32'(bus.busy),       32'(e_busy));
        check({tag, ".coef_valid"}, 32'(bus.coef_valid), 32'(beat >= 0));
        check({tag, ".coef_rsel"},  32'(bus.coef_rsel),  32'(e_rsel));
        check({tag, ".coef_last"},  32'(bus.coef_last),  32'(beat == ORDER - 1));
        check({tag, ".err"},        32'(bus.err),        32'(exp_err));
        check({tag, ".frame_cnt"},  32'(bus.frame_cnt),  32'(exp_fc));
        check({tag, ".drop_cnt"},   32'(bus.drop_cnt),   32'(exp_dc));
    endtask

    // Entered on the start-pulse cycle; returns in the first cycle after the run.
    task automatic run_phase(input bit is_ac, input int delay, input bit level, output bit ok);
        bit d;
        ok = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            check_cycle(is_ac ? "ac_run" : "lev_run", is_ac && k == 0, !is_ac && k == 0, 1'b0, 1'b1, -1);
            d = (k == delay) || (level && k >= delay) || (k == 0 && 1'($urandom));
            if (is_ac) begin
                bus.ac_done  = d;
                bus.lev_done = 1'($urandom);
            end else begin
                bus.lev_done = d;
                bus.ac_done  = 1'($urandom);
            end
            bus.coef_ready = 1'($urandom);
            tick();
            if (k >= 1 && d) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_out(input int stall_beat, input int stall_len, input bit rnd,
                           input int abort_beat, output bit aborted);
        int  beat  = 0;
        int  stall = 0;
        int  guard = 0;
        bit  rdy;
        aborted = 1'b0;
        while (beat < ORDER) begin
            check_cycle("out", 1'b0, 1'b0, 1'b0, 1'b1, beat);
            if (beat == abort_beat) begin
                reset = 1'b1;
                tick();
                reset   = 1'b0;
                exp_fc  = '0;
                exp_dc  = '0;
                exp_err = 1'b0;
                check_cycle("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, -1);
                aborted = 1'b1;
                return;
            end
            rdy = rnd ? ($urandom_range(2, 0) != 0) : !(beat == stall_beat && stall < stall_len);
            if (!rdy && beat == stall_beat) stall++;
            bus.coef_ready = rdy;
            bus.ac_done    = 1'($urandom);
            bus.lev_done   = 1'($urandom);
            tick();
            if (rdy) beat++;
            guard++;
            if (guard > 400) begin
                check("out_timeout", 32'(beat), 32'(ORDER));
                aborted = 1'b1;
                return;
            end
        end
        check("beats_accepted", 32'(beat), 32'(ORDER));
    endtask

    // Precondition: current cycle is IDLE. Returns in the IDLE cycle after the frame.
    task automatic run_frame(input int ac_dly, input bit ac_lvl, input int lev_dly, input bit lev_lvl,
                             input int stall_beat, input int stall_len, input bit rnd,
                             input int abort_beat, input bit keep_rdy);
        bit ok;
        bit aborted;
        check_cycle("idle_gap", 1'b0, 1'b0, 1'b0, 1'b0, -1);
        bus.frame_rdy = 1'b1;
        bus.ac_done   = 1'($urandom);
        bus.lev_done  = 1'($urandom);
        tick();
        run_phase(1'b1, ac_dly, ac_lvl, ok);
        if (ok) run_phase(1'b0, lev_dly, lev_lvl, ok);
        if (ok) begin
            run_out(stall_beat, stall_len, rnd, abort_beat, aborted);
            if (aborted) begin
                bus.frame_rdy = 1'b0;
                bus.ac_done   = 1'b0;
                bus.lev_done  = 1'b0;
                return;
            end
            exp_fc = exp_fc + 1'b1;
            check_cycle("ack", 1'b0, 1'b0, 1'b1, 1'b1, -1);
        end else begin
            exp_dc  = exp_dc + 1'b1;
            exp_err = 1'b1;
            check_cycle("drop", 1'b0, 1'b0, 1'b1, 1'b1, -1);
        end
        if (!keep_rdy) bus.frame_rdy = 1'b0;
        bus.ac_done  = 1'b0;
        bus.lev_done = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, -1);
            bus.ac_done    = 1'($urandom);
            bus.lev_done   = 1'($urandom);
            bus.coef_ready = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        bit keep;
        reset          = 1'b1;
        bus.frame_rdy  = 1'b0;
        bus.ac_done    = 1'b0;
        bus.lev_done   = 1'b0;
        bus.coef_ready = 1'b0;
        exp_fc         = '0;
        exp_dc         = '0;
        exp_err        = 1'b0;
        tick();
        tick();
        check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, -1);
        reset = 1'b0;

        // Nominal frame, then back-pressure on beat index 3 (rsel 0x008) for 3 cycles.
        run_frame(5, 1'b0, 6, 1'b0, -1, 0, 1'b0, -1, 1'b0);
        idle(2);
        run_frame(3, 1'b0, 4, 1'b0, 3, 3, 1'b0, -1, 1'b0);
        idle(1);
        // Watchdog drop on autocorrelation, then on Levinson; good frame keeps err.
        run_frame(TIMEOUT + 5, 1'b0, 2, 1'b0, -1, 0, 1'b0, -1, 1'b0);
        idle(1);
        run_frame(2, 1'b0, 3, 1'b0, -1, 0, 1'b0, -1, 1'b0);
        run_frame(2, 1'b1, TIMEOUT, 1'b1, -1, 0, 1'b0, -1, 1'b0);
        // Done on the terminal watchdog cycle wins for both engines.
        run_frame(TIMEOUT - 1, 1'b0, TIMEOUT - 1, 1'b0, -1, 0, 1'b0, -1, 1'b0);
        // Reset during streaming of beat index 5 clears everything without an ack.
        run_frame(3, 1'b1, 3, 1'b1, -1, 0, 1'b0, 5, 1'b0);
        idle(1);
        check("post_reset_cnt", 32'(bus.frame_cnt), 32'(0));
        // frame_rdy held high: three frames back to back, fourth wraps the counter.
        run_frame(2, 1'b0, 2, 1'b0, -1, 0, 1'b1, -1, 1'b1);
        run_frame(4, 1'b1, 3, 1'b0, -1, 0, 1'b1, -1, 1'b1);
        run_frame(3, 1'b0, 5, 1'b1, -1, 0, 1'b1, -1, 1'b1);
        check("frame_cnt_three", 32'(bus.frame_cnt), 32'(3));
        run_frame(2, 1'b0, 2, 1'b0, -1, 0, 1'b1, -1, 1'b0);
        check("frame_cnt_wrap", 32'(bus.frame_cnt), 32'(0));

        for (int f = 0; f < 40; f++) begin
            keep = 1'($urandom);
            run_frame($urandom_range(TIMEOUT + 1, 1), 1'($urandom),
                      $urandom_range(TIMEOUT + 1, 1), 1'($urandom),
                      -1, 0, 1'b1,
                      ($urandom_range(9, 0) == 0) ? int'($urandom_range(ORDER - 1, 0)) : -1,
                      keep);
            if (!keep) idle($urandom_range(3, 0));
        end
        bus.frame_rdy = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
